// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: responder FSM states and bus constants.
// Also imported by the CoreSCCB initiator benches.
package sccb_pkg;

  localparam int unsigned SCCB_BITS_PER_PHASE = 9;
  localparam logic [6:0]  OV7670_ID           = 7'h21;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ID_BYTE,
    ST_ID_ACK,
    ST_SUB_BYTE,
    ST_SUB_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_IGNORE
  } sccb_state_e;

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronises sioc/siod onto the system clock and decodes sioc edges and
// START/STOP conditions as registered single-cycle events.
module sccb_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_rise,
  output logic o_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_q;
  logic                   r_sda_q;
  logic                   w_scl;
  logic                   w_sda;

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  // Idle bus is high on both lines, so resetting to '1 avoids a false edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_q    <= 1'b1;
      r_sda_q    <= 1'b1;
      o_sda      <= 1'b1;
      o_rise     <= 1'b0;
      o_fall     <= 1'b0;
      o_start    <= 1'b0;
      o_stop     <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_q    <= w_scl;
      r_sda_q    <= w_sda;
      o_sda      <= w_sda;
      o_rise     <= w_scl & ~r_scl_q;
      o_fall     <= ~w_scl & r_scl_q;
      o_start    <= w_scl & r_scl_q & r_sda_q & ~w_sda;
      o_stop     <= w_scl & r_scl_q & ~r_sda_q & w_sda;
    end
  end

endmodule

// File: rtl/sccb_responder.sv
// SCCB camera-side target: decodes 3-phase write, 2-phase write and 2-phase
// read cycles and presents them on a simple external register-file port.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [6:0]  DEVICE_ID   = OV7670_ID,
  parameter bit          DRIVE_ACK   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       xclk,
  input  logic       reset,
  input  logic       sioc,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       xfer_done,
  output logic       id_match
);

  logic w_sda;
  logic w_rise;
  logic w_fall;
  logic w_start;
  logic w_stop;

  sccb_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .i_clk  (xclk),
    .i_rst  (reset),
    .i_scl  (sioc),
    .i_sda  (siod_in),
    .o_sda  (w_sda),
    .o_rise (w_rise),
    .o_fall (w_fall),
    .o_start(w_start),
    .o_stop (w_stop)
  );

  sccb_state_e r_state;
  logic [6:0]  r_shift;
  logic [3:0]  r_bitcnt;
  logic        r_rw;
  logic        r_ack_rose;
  logic        r_oe;
  logic        r_busy;
  logic        r_done;
  logic        r_match;
  logic        r_we;
  logic [7:0]  r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  w_byte;
  logic        w_last;

  assign w_byte = {r_shift, w_sda};
  assign w_last = (r_bitcnt == 4'd7);

  assign siod_oe   = r_oe;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_we    = r_we;
  assign busy      = r_busy;
  assign xfer_done = r_done;
  assign id_match  = r_match;

  always_ff @(posedge xclk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_rw       <= 1'b0;
      r_ack_rose <= 1'b0;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_match    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      if (w_rise) begin
        unique case (r_state)
          ST_ID_BYTE, ST_SUB_BYTE, ST_WR_BYTE: begin
            r_shift  <= w_byte[6:0];
            r_bitcnt <= r_bitcnt + 4'd1;
            if (w_last) begin
              r_bitcnt   <= '0;
              r_ack_rose <= 1'b0;
              if (r_state == ST_ID_BYTE) begin
                if (w_byte[7:1] == DEVICE_ID) begin
                  r_match <= 1'b1;
                  r_rw    <= w_byte[0];
                  r_state <= ST_ID_ACK;
                end else begin
                  r_match <= 1'b0;
                  r_state <= ST_IGNORE;
                end
              end else if (r_state == ST_SUB_BYTE) begin
                r_addr  <= w_byte;
                r_state <= ST_SUB_ACK;
              end else begin
                r_wdata <= w_byte;
                r_we    <= 1'b1;
                r_state <= ST_WR_ACK;
              end
            end
          end
          ST_ID_ACK, ST_SUB_ACK, ST_WR_ACK: r_ack_rose <= 1'b1;
          ST_RD_BYTE: begin
            // Rise number 9 is the initiator's NA bit: sampled and ignored.
            if (r_bitcnt == 4'(SCCB_BITS_PER_PHASE - 1)) r_state <= ST_IGNORE;
            else r_bitcnt <= r_bitcnt + 4'd1;
          end
          default: ;
        endcase
      end else if (w_fall) begin
        unique case (r_state)
          ST_ID_ACK, ST_SUB_ACK, ST_WR_ACK: begin
            if (!r_ack_rose) begin
              r_oe <= DRIVE_ACK;
            end else begin
              r_oe <= 1'b0;
              if (r_state == ST_ID_ACK) begin
                if (r_rw) begin
                  r_shift  <= reg_rdata[6:0];
                  r_oe     <= ~reg_rdata[7];
                  r_bitcnt <= '0;
                  r_state  <= ST_RD_BYTE;
                end else begin
                  r_state <= ST_SUB_BYTE;
                end
              end else if (r_state == ST_SUB_ACK) begin
                r_state <= ST_WR_BYTE;
              end else begin
                r_state <= ST_IGNORE;
              end
            end
          end
          ST_RD_BYTE: begin
            if (r_bitcnt < 4'd8) begin
              r_oe    <= ~r_shift[6];
              r_shift <= {r_shift[5:0], 1'b0};
            end else begin
              r_oe <= 1'b0;
            end
          end
          default: ;
        endcase
      end else if (w_start) begin
        r_state  <= ST_ID_BYTE;
        r_bitcnt <= '0;
        r_oe     <= 1'b0;
        r_busy   <= 1'b1;
        r_match  <= 1'b0;
      end else if (w_stop) begin
        r_state <= ST_IDLE;
        r_oe    <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= r_busy & r_match;
      end
    end
  end

endmodule

// File: tb/tb_sccb_responder.sv
// Bench for sccb_responder: bit-banged SCCB initiator, scoreboard queues for
// per-bit siod_oe, register writes and transfer completions.
module tb_sccb_responder;
  import sccb_pkg::*;

  localparam int Q = 100;

  logic       xclk = 1'b0;
  logic       reset = 1'b1;
  logic       tb_scl = 1'b1;
  logic       tb_sda = 1'b1;
  logic [7:0] rdata = 8'h76;

  logic       oe0, oe1, we0, we1, busy0, busy1, done0, done1, idm0, idm1;
  logic [7:0] addr0, addr1, wd0, wd1;
  logic       bus0, bus1;

  assign bus0 = tb_sda & ~oe0;
  assign bus1 = tb_sda & ~oe1;

  always #5 xclk = ~xclk;

  sccb_responder #(.DEVICE_ID(OV7670_ID), .DRIVE_ACK(1'b1), .SYNC_STAGES(2)) u_dut (
    .xclk(xclk), .reset(reset), .sioc(tb_scl), .siod_in(bus0), .siod_oe(oe0),
    .reg_addr(addr0), .reg_wdata(wd0), .reg_we(we0), .reg_rdata(rdata),
    .busy(busy0), .xfer_done(done0), .id_match(idm0));

  sccb_responder #(.DEVICE_ID(OV7670_ID), .DRIVE_ACK(1'b0), .SYNC_STAGES(2)) u_dut_noack (
    .xclk(xclk), .reset(reset), .sioc(tb_scl), .siod_in(bus1), .siod_oe(oe1),
    .reg_addr(addr1), .reg_wdata(wd1), .reg_we(we1), .reg_rdata(rdata),
    .busy(busy1), .xfer_done(done1), .id_match(idm1));

  int n_vec = 0;
  int n_err = 0;
  int done1_cnt = 0;

  typedef struct { logic oe; string tag; } bit_exp_t;
  bit_exp_t    bit_q[$];
  logic [15:0] wr_q0[$];
  logic [15:0] wr_q1[$];
  logic [7:0]  done_q[$];
  logic        oe0_seen = 1'b0;
  logic        oe1_seen = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Per-bit monitor: siod_oe and busy sampled mid-way through sioc high.
  initial begin : mon_bits
    bit_exp_t e;
    forever begin
      @(posedge tb_scl);
      if (bit_q.size() != 0) begin
        e = bit_q.pop_front();
        #Q;
        chk1({e.tag, " oe"}, oe0, e.oe);
        chk1({e.tag, " busy"}, busy0, 1'b1);
      end
    end
  end

  // Register-port monitor: every strobe must match the head of its queue.
  always @(negedge xclk) begin
    if (oe0) oe0_seen = 1'b1;
    if (oe1) oe1_seen = 1'b1;
    if (done1) done1_cnt++;
    if (we0) begin
      if (wr_q0.size() == 0) chkn("unexpected reg_we dut0", 1, 0);
      else chk16("reg_we dut0 addr/data", {addr0, wd0}, wr_q0.pop_front());
    end
    if (we1) begin
      if (wr_q1.size() == 0) chkn("unexpected reg_we dut1", 1, 0);
      else chk16("reg_we dut1 addr/data", {addr1, wd1}, wr_q1.pop_front());
    end
    if (done0) begin
      if (done_q.size() == 0) chkn("unexpected xfer_done", 1, 0);
      else chk8("xfer_done reg_addr", addr0, done_q.pop_front());
    end
  end

  task automatic bit_tx(input logic b, input logic exp_oe, input string tag);
    tb_sda = b;
    #Q;
    bit_q.push_back('{oe: exp_oe, tag: tag});
    tb_scl = 1'b1;
    #(2*Q);
    tb_scl = 1'b0;
    #Q;
  endtask

  task automatic byte_tx(input logic [7:0] b, input logic ack, input string tag);
    for (int i = 7; i >= 0; i--) bit_tx(b[i], 1'b0, {tag, " data"});
    bit_tx(1'b1, ack, {tag, " ack"});
  endtask

  task automatic byte_rx(input logic [7:0] exp, input string tag);
    for (int i = 7; i >= 0; i--) bit_tx(1'b1, ~exp[i], {tag, " rdbit"});
    bit_tx(1'b1, 1'b0, {tag, " na"});
  endtask

  task automatic start_c();
    tb_sda = 1'b1; #Q;
    tb_scl = 1'b1; #Q;
    tb_sda = 1'b0; #Q;
    tb_scl = 1'b0; #Q;
  endtask

  task automatic stop_c();
    tb_sda = 1'b0; #Q;
    tb_scl = 1'b1; #Q;
    tb_sda = 1'b1; #(2*Q);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    repeat (3) @(posedge xclk);
    #1;
    chk1("reset siod_oe", oe0, 1'b0);
    chk8("reset reg_addr", addr0, 8'h00);
    chk1("reset busy", busy0, 1'b0);
    chk1("reset id_match", idm0, 1'b0);
    chk1("reset reg_we", we0, 1'b0);
    @(negedge xclk);
    reset = 1'b0;
    #(2*Q);

    // 3-phase write 0x42 / 0x12 / 0x80
    oe1_seen = 1'b0;
    start_c();
    byte_tx(8'h42, 1'b1, "s1 id");
    byte_tx(8'h12, 1'b1, "s1 sub");
    wr_q0.push_back(16'h1280);
    wr_q1.push_back(16'h1280);
    byte_tx(8'h80, 1'b1, "s1 wdata");
    done_q.push_back(8'h12);
    stop_c();
    chk1("s1 busy after stop", busy0, 1'b0);
    chk1("s1 id_match", idm0, 1'b1);
    chk1("s1 noack id_match", idm1, 1'b1);
    chk1("s1 noack busy after stop", busy1, 1'b0);
    chk1("s1 noack siod_oe ever", oe1_seen, 1'b0);
    chkn("s1 writes drained", wr_q0.size() + wr_q1.size(), 0);

    // 2-phase write 0x0A, then 2-phase read returning 0x76
    start_c();
    byte_tx(8'h42, 1'b1, "s2 id");
    byte_tx(8'h0A, 1'b1, "s2 sub");
    done_q.push_back(8'h0A);
    stop_c();
    chk8("s2 pointer after 2-phase write", addr0, 8'h0A);
    start_c();
    byte_tx(8'h43, 1'b1, "s2 rd id");
    byte_rx(8'h76, "s2 rd");
    done_q.push_back(8'h0A);
    stop_c();
    chk8("s2 pointer after read", addr0, 8'h0A);
    chkn("s2 done drained", done_q.size(), 0);

    // mismatched ID 0x60
    oe0_seen = 1'b0;
    start_c();
    byte_tx(8'h60, 1'b0, "s3 id");
    byte_tx(8'h12, 1'b0, "s3 sub");
    byte_tx(8'h80, 1'b0, "s3 wdata");
    stop_c();
    chk1("s3 id_match", idm0, 1'b0);
    chk1("s3 siod_oe ever", oe0_seen, 1'b0);
    chk8("s3 pointer untouched", addr0, 8'h0A);

    // repeated START 4 bits into the sub-address, then a full write
    start_c();
    byte_tx(8'h42, 1'b1, "s4 id");
    bit_tx(1'b0, 1'b0, "s4 partial");
    bit_tx(1'b0, 1'b0, "s4 partial");
    bit_tx(1'b0, 1'b1 & 1'b0, "s4 partial");
    bit_tx(1'b1, 1'b0, "s4 partial");
    start_c();
    byte_tx(8'h42, 1'b1, "s4 id2");
    byte_tx(8'h11, 1'b1, "s4 sub");
    wr_q0.push_back(16'h113C);
    wr_q1.push_back(16'h113C);
    byte_tx(8'h3C, 1'b1, "s4 wdata");
    done_q.push_back(8'h11);
    stop_c();
    chkn("s4 writes drained", wr_q0.size() + wr_q1.size(), 0);

    // reset while driving the first read bit (~0x76 bit7 = 1)
    start_c();
    byte_tx(8'h43, 1'b1, "s5 id");
    tb_sda = 1'b1;
    #Q;
    chk1("s5 siod_oe before reset", oe0, 1'b1);
    reset = 1'b1;
    #1;
    chk1("s5 siod_oe in reset", oe0, 1'b0);
    chk1("s5 busy in reset", busy0, 1'b0);
    chk1("s5 id_match in reset", idm0, 1'b0);
    chk1("s5 xfer_done in reset", done0, 1'b0);
    chk8("s5 reg_addr in reset", addr0, 8'h00);
    chk8("s5 reg_wdata in reset", wd0, 8'h00);
    #Q;
    reset = 1'b0;
    #Q;
    stop_c();
    chk8("s5 reg_addr after release", addr0, 8'h00);
    chk1("s5 busy after stop", busy0, 1'b0);

    #(4*Q);
    chkn("final done queue empty", done_q.size(), 0);
    chkn("final write queues empty", wr_q0.size() + wr_q1.size(), 0);
    chkn("final bit queue empty", bit_q.size(), 0);
    chkn("noack dut transfer count", done1_cnt, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sccb_responder.md
Name: sccb_responder

Overview:
- SCCB target (camera-side) model that sits on the same sioc/siod bus as the CoreSCCB initiator.
- Used on the FPGA test design to close the loop on the initiator without an OV7670 attached; stands in for the camera's register interface.
- Oversamples sioc/siod on the system clock, decodes start/stop, 3-phase write, 2-phase write and 2-phase read cycles.
- Exposes a simple synchronous register-file port; the register storage is external.

Parameters:
- DEVICE_ID, 7'h21, 7-bit target ID; OV7670 equivalent, 0x42 write / 0x43 read.
- DRIVE_ACK, 1, 1 = drive the don't-care (9th) bit low after received bytes; 0 = leave siod released.
- SYNC_STAGES, 2, synchroniser depth on sioc and siod_in (minimum 2).

Ports:
- xclk  input  1  system clock, ≥ 20× sioc frequency (10 MHz nominal).
- reset  input  1  asynchronous, active-high reset.
- sioc  input  1  SCCB clock from the initiator.
- siod_in  input  1  sampled value of the siod pad.
- siod_oe  output  1  1 = pull siod low (open-drain); the pad never drives high.
- reg_addr  output  8  current sub-address pointer.
- reg_wdata  output  8  write data to the register file.
- reg_we  output  1  one-cycle write strobe.
- reg_rdata  input  8  register file read data, combinational on reg_addr.
- busy  output  1  high from a detected start until a detected stop.
- xfer_done  output  1  one-cycle pulse at stop after an addressed transaction.
- id_match  output  1  last received ID matched DEVICE_ID; held until the next start.

Behaviour:
- Clock and reset: one clock, xclk. Reset is asynchronous and active-high. While reset is asserted, all outputs are 0, the sub-address pointer is 0x00, and the state is IDLE. Asserting reset mid-transaction releases siod_oe immediately.
- Input conditioning: sioc and siod_in pass through SYNC_STAGES flops, then one edge register. Events:
  - rise = sioc 0→1
  - fall = sioc 1→0
  - START = siod 1→0 while sioc is high in both the previous and current synced sample
  - STOP = siod 0→1 under the same sioc condition
  - Event latency is SYNC_STAGES+1 xclk cycles.
- Event priority: sioc edge > START/STOP. START and STOP are accepted in any state, including mid-byte.
  - START (repeated start included): go to ID_BYTE, clear the bit counter, release siod_oe, set busy=1.
  - STOP: go to IDLE, release siod_oe, set busy=0. Pulse xfer_done if id_match=1.
- Bit handling: data bits are sampled MSB first on rise. Responder-driven bits change on fall only.
- States:
  - IDLE: wait for START.
  - ID_BYTE: shift 8 bits. After the 8th rise, compare bits[7:1] to DEVICE_ID.
    - Match: set id_match=1, latch rw=bit0, go to ID_ACK.
    - No match: id_match=0, go to IGNORE.
  - ID_ACK: on the next fall, siod_oe = DRIVE_ACK. On the 9th rise, keep driving. On the following fall, release siod_oe, then:
    - rw=0: go to SUB_BYTE.
    - rw=1: load the shifter from reg_rdata and go to RD_BYTE, driving bit7 on that same fall (siod_oe = ~bit).
  - SUB_BYTE: receive 8 bits. After the 8th rise, load the sub-address pointer (reg_addr). ACK phase as in ID_ACK, then go to WR_BYTE.
  - WR_BYTE: receive 8 bits. The cycle after the 8th rise, reg_wdata = byte and reg_we=1 for exactly one xclk; the pointer is unchanged (no auto-increment). ACK phase, then go to IGNORE. Further bytes before STOP are ignored.
  - RD_BYTE: drive bits 6..0 on successive falls. On the fall after bit0, release siod_oe. The 9th (NA) rise is sampled and ignored; go to IGNORE.
  - IGNORE: siod_oe=0. Wait for START or STOP.
- A 2-phase write is an ID_BYTE write followed by STOP after SUB_BYTE. It updates the pointer only; no reg_we.
- siod_oe is never asserted outside the ACK phase and RD_BYTE.
- A mismatched ID never drives the bus and never strobes reg_we.

Decomposition:
- Shared package sccb_pkg, containing:
  - state enum
  - SCCB_BITS_PER_PHASE = 9
  - OV7670_ID = 7'h21
  - reused by CoreSCCB benches.
- One natural sub-module: sccb_line_sync, holding the synchronisers plus the rise/fall/START/STOP detection. It is parameterised by SYNC_STAGES.

Test Plan:
- Bus sequence START, 0x42, 0x12, 0x80, STOP → siod_oe low during each of the three 9th bits; one reg_we with reg_addr=0x12, reg_wdata=0x80; one xfer_done; busy high throughout.
- Bus sequence START, 0x42, 0x0A, STOP, then START, 0x43, 8 clocks, NA, STOP, with reg_rdata=0x76 → reg_addr=0x0A; siod_oe pattern on the read byte = ~0x76 MSB first; siod_oe released on the NA bit; no reg_we.
- Bus sequence START, 0x60, 0x12, 0x80, STOP → id_match=0; siod_oe never asserted; no reg_we; no xfer_done.
- Repeated START issued after 4 bits of SUB_BYTE, then a full write 0x42/0x11/0x3C → only one reg_we (addr 0x11, data 0x3C).
- Reset asserted during RD_BYTE while siod_oe=1 → siod_oe=0 in the same cycle; all outputs 0; reg_addr=0x00 after release.
- Parameter variant DRIVE_ACK=0 on the write of the first scenario → siod_oe stays 0 for the whole transfer; the write still completes.
